// File: rtl/call_ret_seq_pkg.sv
// ----------------------------------------------------------------------------
// call_ret_seq_pkg
// Shared definitions for the CALL/RET sequencer:
//   - AW_DEFAULT          : default address/data width
//   - STK_NOP..STK_PEEK   : 2-bit stack command opcodes driven on stk_rw
//   - state_e             : sequencer FSM state encoding
// ----------------------------------------------------------------------------
package call_ret_seq_pkg;

  localparam int AW_DEFAULT = 8;

  // Stack command opcodes
  localparam logic [1:0] STK_NOP  = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;
  localparam logic [1:0] STK_PEEK = 2'b11;  // defined for the stack, never issued here

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_POP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOAD = 3'd4
  } state_e;

endpackage

// File: rtl/call_ret_seq_depth_cnt.sv
// ----------------------------------------------------------------------------
// stk_depth_cnt
// Tracks how many entries the external return stack currently holds,
// range 0..DEPTH.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (depth -> 0)
//   inc_i    : one entry pushed this cycle
//   dec_i    : one entry popped this cycle
//   full_o   : depth == DEPTH
//   empty_o  : depth == 0
// ----------------------------------------------------------------------------
module stk_depth_cnt #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] depth_q;
  logic [CW-1:0] depth_d;

  assign full_o  = (depth_q == CW'(DEPTH));
  assign empty_o = (depth_q == '0);

  // Saturate at both ends so a stray inc/dec can never wrap the count.
  always_comb begin
    depth_d = depth_q;
    if (inc_i && !dec_i && !full_o) begin
      depth_d = depth_q + CW'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      depth_d = depth_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/call_ret_seq.sv
// ----------------------------------------------------------------------------
// call_ret_seq
// Sequences CALL and RET instructions against an external return-address
// stack. A CALL pushes pc_in+1 and loads target into the PC; a RET pops the
// stack, waits POP_LAT cycles for the read data and loads it into the PC.
// Stack overflow/underflow are reported on sticky flags instead of touching
// the stack or the PC.
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   call_req  in   CALL request pulse (sampled only when idle)
//   ret_req   in   RET request pulse (sampled only when idle, CALL wins)
//   pc_in     in   current PC
//   target    in   CALL destination
//   stk_addr  in   stack read data (popped return address)
//   stk_rw    out  stack command (NOP/PUSH/POP)
//   stk_data  out  return address to push
//   pc_out    out  new PC value
//   pc_load   out  one-cycle PC load strobe
//   busy      out  sequencer not idle
//   done      out  one-cycle completion pulse (also for error completions)
//   ovf       out  sticky overflow flag
//   udf       out  sticky underflow flag
//   err_clr   in   synchronous clear of ovf/udf (a new error wins)
// ----------------------------------------------------------------------------
module call_ret_seq
  import call_ret_seq_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int DEPTH   = 16,
  parameter int POP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          call_req,
  input  logic          ret_req,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stk_addr,
  output logic [1:0]    stk_rw,
  output logic [AW-1:0] stk_data,
  output logic [AW-1:0] pc_out,
  output logic          pc_load,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  // Wait counter only has to reach POP_LAT-1; keep it at least one bit wide.
  localparam int WCW        = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;
  localparam int POP_LAT_M1 = (POP_LAT > 0) ? (POP_LAT - 1) : 0;

  state_e         state_q, state_d;
  logic [AW-1:0]  ret_addr_q, ret_addr_d;
  logic [AW-1:0]  pc_out_q, pc_out_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           err_done_q, err_done_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  logic           set_ovf;
  logic           set_udf;
  logic           push_inc;
  logic           pop_dec;
  logic           stk_full;
  logic           stk_empty;

  stk_depth_cnt #(
    .DEPTH (DEPTH)
  ) u_depth (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (push_inc),
    .dec_i   (pop_dec),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ret_addr_d = ret_addr_q;
    pc_out_d   = pc_out_q;
    wait_cnt_d = wait_cnt_q;
    err_done_d = 1'b0;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    push_inc   = 1'b0;
    pop_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // CALL has priority; a simultaneous RET is simply dropped.
        if (call_req) begin
          if (stk_full) begin
            set_ovf    = 1'b1;
            err_done_d = 1'b1;
          end else begin
            ret_addr_d = pc_in + AW'(1);  // wraps naturally at 2^AW
            pc_out_d   = target;          // latched now, strobed in LOAD
            state_d    = ST_PUSH;
          end
        end else if (ret_req) begin
          if (stk_empty) begin
            set_udf    = 1'b1;
            err_done_d = 1'b1;
          end else begin
            state_d = ST_POP;
          end
        end
      end

      ST_PUSH: begin
        push_inc = 1'b1;
        state_d  = ST_LOAD;
      end

      ST_POP: begin
        pop_dec    = 1'b1;
        wait_cnt_d = '0;
        if (POP_LAT == 0) begin
          // Zero-latency stack: read data is already valid alongside the pop.
          pc_out_d = stk_addr;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Read data is valid in the last wait cycle; capture it on the way out.
        if (wait_cnt_q == WCW'(POP_LAT_M1)) begin
          pc_out_d = stk_addr;
          state_d  = ST_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      ST_LOAD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new error in the same cycle beats the clear.
  always_comb begin
    ovf_d = set_ovf | (ovf_q & ~err_clr);
    udf_d = set_udf | (udf_q & ~err_clr);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ret_addr_q <= '0;
      pc_out_q   <= '0;
      wait_cnt_q <= '0;
      err_done_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_addr_q <= ret_addr_d;
      pc_out_q   <= pc_out_d;
      wait_cnt_q <= wait_cnt_d;
      err_done_q <= err_done_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state, so reset clears them at once)
  // --------------------------------------------------------------------------
  always_comb begin
    stk_rw = STK_NOP;
    case (state_q)
      ST_PUSH: stk_rw = STK_PUSH;
      ST_POP:  stk_rw = STK_POP;
      default: stk_rw = STK_NOP;
    endcase
  end

  assign stk_data = ret_addr_q;
  assign pc_out   = pc_out_q;
  assign pc_load  = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  // Error completions stay in IDLE and pulse done from a dedicated register.
  assign done     = (state_q == ST_LOAD) | err_done_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule

// File: tb/tb_call_ret_seq.sv
// ----------------------------------------------------------------------------
// tb_call_ret_seq
// Directed scenarios followed by randomized CALL/RET/clear traffic, checked
// against a queue-based model of the return stack. The bench also plays the
// external stack memory, returning popped data POP_LAT cycles after a pop.
// ----------------------------------------------------------------------------
module tb_call_ret_seq;

  localparam int AW      = 8;
  localparam int DEPTH   = 16;
  localparam int POP_LAT = 1;

  logic          clk;
  logic          rst_n;
  logic          call_req;
  logic          ret_req;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] target;
  logic [AW-1:0] stk_addr;
  logic [1:0]    stk_rw;
  logic [AW-1:0] stk_data;
  logic [AW-1:0] pc_out;
  logic          pc_load;
  logic          busy;
  logic          done;
  logic          ovf;
  logic          udf;
  logic          err_clr;

  call_ret_seq #(
    .AW      (AW),
    .DEPTH   (DEPTH),
    .POP_LAT (POP_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .call_req (call_req),
    .ret_req  (ret_req),
    .pc_in    (pc_in),
    .target   (target),
    .stk_addr (stk_addr),
    .stk_rw   (stk_rw),
    .stk_data (stk_data),
    .pc_out   (pc_out),
    .pc_load  (pc_load),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .udf      (udf),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // External stack memory emulation (single-cycle read latency)
  // --------------------------------------------------------------------------
  logic [AW-1:0] emem [0:31];
  int            esp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      esp <= 0;
    end else if (stk_rw == 2'b01 && esp < 32) begin
      emem[esp] <= stk_data;
      esp       <= esp + 1;
    end else if (stk_rw == 2'b10 && esp > 0) begin
      esp <= esp - 1;
    end
  end

  // Read data is valid only in the cycle after the pop; junk otherwise.
  always @(posedge clk) begin
    if (stk_rw == 2'b10 && esp > 0) stk_addr <= emem[esp-1];
    else                            stk_addr <= AW'($urandom);
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [AW-1:0] m_stk[$];
  logic [AW-1:0] m_pc_out;
  logic          m_ovf;
  logic          m_udf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] e_rw, input logic e_busy,
                         input logic e_done, input logic e_load);
    chk({tag, ".stk_rw"},  32'(stk_rw),  32'(e_rw));
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".done"},    32'(done),    32'(e_done));
    chk({tag, ".pc_load"}, 32'(pc_load), 32'(e_load));
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(udf), 32'(m_udf));
  endtask

  // Requests raised while busy must be ignored.
  task automatic drive_noise();
    call_req = 1'($urandom);
    ret_req  = 1'($urandom);
    pc_in    = AW'($urandom);
    target   = AW'($urandom);
  endtask

  task automatic quiet();
    call_req = 1'b0;
    ret_req  = 1'b0;
  endtask

  // One transaction; entered and left at a negedge with the DUT idle.
  task automatic do_op(input logic c, input logic r, input logic [AW-1:0] pc,
                       input logic [AW-1:0] tgt, input logic clr);
    logic [AW-1:0] exp_ret;
    call_req = c;
    ret_req  = r;
    pc_in    = pc;
    target   = tgt;
    err_clr  = clr;
    @(negedge clk);
    err_clr = 1'b0;
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (c) begin
      if (m_stk.size() < DEPTH) begin
        exp_ret = pc + AW'(1);
        chk_ctl("call.push", 2'b01, 1'b1, 1'b0, 1'b0);
        chk("call.stk_data", 32'(stk_data), 32'(exp_ret));
        drive_noise();
        @(negedge clk);
        chk_ctl("call.load", 2'b00, 1'b1, 1'b1, 1'b1);
        chk("call.pc_out", 32'(pc_out), 32'(tgt));
        drive_noise();
        m_stk.push_back(exp_ret);
        m_pc_out = tgt;
      end else begin
        m_ovf = 1'b1;
        quiet();
        chk_ctl("call.ovf", 2'b00, 1'b0, 1'b1, 1'b0);
      end
    end else if (r) begin
      if (m_stk.size() > 0) begin
        chk_ctl("ret.pop", 2'b10, 1'b1, 1'b0, 1'b0);
        drive_noise();
        for (int i = 0; i < POP_LAT; i++) begin
          @(negedge clk);
          chk_ctl("ret.wait", 2'b00, 1'b1, 1'b0, 1'b0);
          drive_noise();
        end
        @(negedge clk);
        m_pc_out = m_stk.pop_back();
        chk_ctl("ret.load", 2'b00, 1'b1, 1'b1, 1'b1);
        chk("ret.pc_out", 32'(pc_out), 32'(m_pc_out));
        drive_noise();
      end else begin
        m_udf = 1'b1;
        quiet();
        chk_ctl("ret.udf", 2'b00, 1'b0, 1'b1, 1'b0);
      end
    end else begin
      quiet();
      chk_ctl("nop", 2'b00, 1'b0, 1'b0, 1'b0);
    end
    chk_flags("op");
    @(negedge clk);
    chk_ctl("idle", 2'b00, 1'b0, 1'b0, 1'b0);
    chk("idle.pc_out", 32'(pc_out), 32'(m_pc_out));
    chk_flags("idle");
    quiet();
  endtask

  task automatic chk_all_zero(input string tag);
    chk_ctl(tag, 2'b00, 1'b0, 1'b0, 1'b0);
    chk({tag, ".stk_data"}, 32'(stk_data), 32'h0);
    chk({tag, ".pc_out"},   32'(pc_out),   32'h0);
    chk({tag, ".ovf"},      32'(ovf),      32'h0);
    chk({tag, ".udf"},      32'(udf),      32'h0);
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_pc_out = '0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    quiet();
    err_clr  = 1'b0;
    pc_in    = '0;
    target   = '0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First request right on the first edge after reset release.
    do_op(1'b1, 1'b0, 8'h10, 8'h40, 1'b0);   // push 0x11, load 0x40
    do_op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);   // pop 0x11

    // CALL and RET together: only CALL happens, depth becomes 1.
    do_op(1'b1, 1'b1, 8'h20, 8'h50, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);   // succeeds (depth was 1)
    do_op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);   // underflow (depth now 0)
    do_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);   // clear

    // Return address wrap.
    do_op(1'b1, 1'b0, 8'hFF, 8'h33, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);

    // Fill to DEPTH, then overflow; clear; error-vs-clear priority.
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_op(1'b1, 1'b0, AW'($urandom), AW'($urandom), 1'b0);
    end
    do_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    do_op(1'b1, 1'b0, 8'h77, 8'h88, 1'b1);   // ovf set wins over clear
    do_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0); // LIFO drain
    end

    // Reset in the middle of a RET (WAIT state).
    do_op(1'b1, 1'b0, 8'h5A, 8'hA5, 1'b0);
    ret_req = 1'b1;
    @(negedge clk);
    quiet();
    chk_ctl("rstwait.pop", 2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_ctl("rstwait.wait", 2'b00, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("rstwait.async");
    @(negedge clk);
    chk_all_zero("rstwait.held");
    rst_n = 1'b1;
    do_op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);   // depth is 0 -> underflow
    do_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic c, r, clr;
      kind = $urandom_range(0, 19);
      c    = (kind < 9) || (kind == 18);
      r    = (kind >= 9 && kind < 18) || (kind == 18);
      clr  = ($urandom_range(0, 7) == 0);
      do_op(c, r, AW'($urandom), AW'($urandom), clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
